// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths and types for the write-back path.
package mips_pkg;
   localparam int DATA_W    = 32;
   localparam int IMM_W     = 16;
   localparam int LUI_SHAMT = IMM_W;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [IMM_W-1:0]  imm_t;
endpackage

// File: rtl/lui_control_select.sv
// Combinational write-back source mux: LUI result {immediate, 0} or memoryData.
module lui_select #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int IMM_W  = mips_pkg::IMM_W
) (
   input  logic [IMM_W-1:0]  immediate,
   input  logic [DATA_W-1:0] memoryData,
   input  logic              luiSignal,
   output logic [DATA_W-1:0] sel
);
   // Zero-filled low half; LUI never sign-extends.
   assign sel = luiSignal ? {immediate, {IMM_W{1'b0}}} : memoryData;
endmodule

// File: rtl/lui_control.sv
// Write-back data select with an optional output register and valid tracking.
module lui_control
   import mips_pkg::*;
#(
   parameter int DATA_W       = mips_pkg::DATA_W,
   parameter int IMM_W        = mips_pkg::IMM_W,
   parameter int REGISTER_OUT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [DATA_W-1:0] out,
   input  logic [IMM_W-1:0]  immediate,
   input  logic              luiSignal,
   input  logic [DATA_W-1:0] memoryData,
   input  logic              inValid,
   output logic              outValid
);
   logic [DATA_W-1:0] sel;

   if (DATA_W != 2*IMM_W) begin : g_bad_width
      $error("lui_control: DATA_W (%0d) must equal 2*IMM_W (%0d)", DATA_W, 2*IMM_W);
   end

   lui_select #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_sel (
      .immediate (immediate),
      .memoryData(memoryData),
      .luiSignal (luiSignal),
      .sel       (sel)
   );

   if (REGISTER_OUT != 0) begin : g_reg
      logic [DATA_W-1:0] out_q;
      logic              vld_q;

      // Idle cycles keep the last result; only the valid flag drops.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
         end else begin
            vld_q <= inValid;
            if (inValid) out_q <= sel;
         end
      end

      assign out      = out_q;
      assign outValid = vld_q;
   end else begin : g_comb
      assign out      = sel;
      assign outValid = inValid;
   end

   a_lui_known: assert property (@(posedge clk) disable iff (!rst_n)
      inValid |-> !$isunknown(luiSignal))
      else $error("lui_control: luiSignal unknown while inValid");
endmodule

// File: tb/tb_lui_control.sv
// Directed vector bench for lui_control, registered and combinational builds.
module tb_lui_control;
   import mips_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n;
   imm_t  immediate;
   logic  luiSignal;
   word_t memoryData;
   logic  inValid;
   word_t out;
   logic  outValid;

   imm_t  c_imm;
   logic  c_lui;
   word_t c_mem;
   logic  c_vld;
   word_t c_out;
   logic  c_out_vld;

   int applied = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lui_control #(.REGISTER_OUT(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .out       (out),
      .immediate (immediate),
      .luiSignal (luiSignal),
      .memoryData(memoryData),
      .inValid   (inValid),
      .outValid  (outValid)
   );

   lui_control #(.REGISTER_OUT(0)) dut_c (
      .clk       (clk),
      .rst_n     (rst_n),
      .out       (c_out),
      .immediate (c_imm),
      .luiSignal (c_lui),
      .memoryData(c_mem),
      .inValid   (c_vld),
      .outValid  (c_out_vld)
   );

   typedef struct {
      logic  rst_n;
      logic  vld;
      logic  lui;
      imm_t  imm;
      word_t mem;
      word_t exp_out;
      logic  exp_vld;
   } vec_t;

   vec_t vecs[$];

   task automatic check_w(input string name, input word_t act, input word_t exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; inValid = 1'b0; luiSignal = 1'b0;
      immediate = '0; memoryData = '0;
      c_imm = '0; c_lui = 1'b0; c_mem = '0; c_vld = 1'b0;

      //              rst  vld lui imm       mem            exp_out        exp_vld
      vecs.push_back('{1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hAAA5_52A5, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 16'hFFFF, 32'hAAA5_52A5, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 16'hFFFF, 32'hAAA5_52A5, 32'hAAA5_52A5, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 16'hFFFF, 32'hAAA5_52A5, 32'hFFFF_0000, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h1357, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 16'h2468, 32'hCAFE_F00D, 32'hFFFF_0000, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 16'h1234, 32'h0000_00FF, 32'h1234_0000, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 16'h1234, 32'h0000_00FF, 32'h0000_00FF, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 16'h1234, 32'h0000_00FF, 32'h1234_0000, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 16'h8000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 16'hBEEF, 32'h1111_1111, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 16'hBEEF, 32'h1111_1111, 32'h0000_0000, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 16'hBEEF, 32'h1234_5678, 32'h1234_5678, 1'b1});

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_n      = vecs[i].rst_n;
         inValid    = vecs[i].vld;
         luiSignal  = vecs[i].lui;
         immediate  = vecs[i].imm;
         memoryData = vecs[i].mem;
         @(posedge clk);
         #1;
         check_w($sformatf("vec%0d out", i), out, vecs[i].exp_out);
         check_b($sformatf("vec%0d outValid", i), outValid, vecs[i].exp_vld);
      end

      // Combinational build: output follows luiSignal between clock edges.
      @(negedge clk);
      c_imm = 16'hFFFF; c_mem = 32'hAAA5_52A5; c_lui = 1'b0; c_vld = 1'b1;
      #1;
      check_w("comb pass out", c_out, 32'hAAA5_52A5);
      check_b("comb pass outValid", c_out_vld, 1'b1);
      c_lui = 1'b1;
      #1;
      check_w("comb lui out", c_out, 32'hFFFF_0000);
      c_vld = 1'b0;
      #1;
      check_b("comb idle outValid", c_out_vld, 1'b0);

      // Reset must not touch the combinational path.
      @(negedge clk);
      rst_n = 1'b0; inValid = 1'b0;
      c_lui = 1'b0; c_vld = 1'b1;
      #1;
      check_w("comb under reset out", c_out, 32'hAAA5_52A5);
      check_b("comb under reset outValid", c_out_vld, 1'b1);
      @(posedge clk);
      #1;
      check_w("reg reset clears out", out, 32'h0000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete, expected finish before 50000");
      $fatal(1);
   end
endmodule
